// File: rtl/inst_encode_loader.sv
// Instruction encoder and program loader.
// Packs field bundles (type, opcode, registers, immediate) into 9-bit instruction
// words and writes them to consecutive instruction-memory addresses. Bundles whose
// fields fall outside the encodable range are rejected and counted, never written.
//
//  state  | meaning
//  S_RUN  | accepting bundles, memory not yet full
//  S_FULL | DEPTH words written; bundles are held off until clear
module inst_encode_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ritype,
    input  logic [2:0]        rop,
    input  logic [1:0]        iop,
    input  logic [2:0]        rs,
    input  logic [2:0]        rt,
    input  logic [7:0]        imm,
    input  logic              shift_dir,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [8:0]        imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              illegal,
    output logic [7:0]        err_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t              state_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [8:0]          imem_wdata_q;
    logic [ADDR_W:0]     count_q;
    logic                full_q;
    logic                illegal_q;
    logic [7:0]          err_count_q;

    logic [8:0]          enc_d;
    logic                legal_d;
    logic                xfer;

    // Field packing and range check; unused fields of each format are ignored.
    always_comb begin
        enc_d   = 9'h000;
        legal_d = 1'b0;
        if (!ritype) begin
            case (rop)
                3'b100: begin
                    enc_d   = {1'b0, rop, rs[1:0], rt};
                    legal_d = (rs[2] == 1'b0);
                end
                3'b101: begin
                    enc_d   = {1'b0, rop, rs, shift_dir, imm[0]};
                    legal_d = (imm[7:1] == 7'd0);
                end
                3'b111: begin
                    enc_d   = {1'b0, rop, imm[4:0]};
                    legal_d = (imm[7:5] == 3'd0);
                end
                default: begin
                    enc_d   = {1'b0, rop, rs, rt[1:0]};
                    legal_d = (rt[2] == 1'b0);
                end
            endcase
        end else if (!iop[1]) begin
            enc_d   = {1'b1, iop, rs, imm[2:0]};
            legal_d = (imm[7:3] == 5'd0);
        end else begin
            enc_d   = {1'b1, iop, rs[0], imm[4:0]};
            legal_d = (rs[2:1] == 2'd0) && (imm[7:5] == 3'd0);
        end
    end

    // Handshake: clear blocks acceptance in its own cycle.
    always_comb begin
        in_ready = (state_q == S_RUN) && !clear;
        xfer     = in_valid && in_ready;
    end

    // Loader FSM with registered strobe, address, data, counters and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 9'h000;
            count_q      <= '0;
            full_q       <= 1'b0;
            illegal_q    <= 1'b0;
            err_count_q  <= 8'd0;
        end else if (clear) begin
            state_q     <= S_RUN;
            imem_we_q   <= 1'b0;
            count_q     <= '0;
            full_q      <= 1'b0;
            illegal_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            imem_we_q <= 1'b0;
            illegal_q <= 1'b0;
            if (xfer) begin
                if (legal_d) begin
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= count_q[ADDR_W-1:0];
                    imem_wdata_q <= enc_d;
                    count_q      <= count_q + (ADDR_W + 1)'(1);
                    if (count_q == LAST_CNT) begin
                        state_q <= S_FULL;
                        full_q  <= 1'b1;
                    end
                end else begin
                    illegal_q <= 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                end
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign illegal    = illegal_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Bench for inst_encode_loader: a 32-deep and a 4-deep loader share one stimulus
// stream; a reference model predicts every output each cycle, and directed steps
// pin key values with hand-computed literals.
module tb_inst_encode_loader;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid;
    logic       ritype, shift_dir;
    logic [2:0] rop, rs, rt;
    logic [1:0] iop;
    logic [7:0] imm;

    logic       rdy5, we5, full5, ill5;
    logic [4:0] addr5;
    logic [8:0] wd5;
    logic [5:0] cnt5;
    logic [7:0] err5;

    logic       rdy2, we2, full2, ill2;
    logic [1:0] addr2;
    logic [8:0] wd2;
    logic [2:0] cnt2;
    logic [7:0] err2;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    inst_encode_loader #(.ADDR_W(5)) dut5 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy5),
        .ritype(ritype), .rop(rop), .iop(iop), .rs(rs), .rt(rt), .imm(imm),
        .shift_dir(shift_dir), .imem_we(we5), .imem_addr(addr5), .imem_wdata(wd5),
        .count(cnt5), .full(full5), .illegal(ill5), .err_count(err5)
    );

    inst_encode_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
        .ritype(ritype), .rop(rop), .iop(iop), .rs(rs), .rt(rt), .imm(imm),
        .shift_dir(shift_dir), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
        .count(cnt2), .full(full2), .illegal(ill2), .err_count(err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the instruction format table.
    function automatic void encode(input int t, input int ro, input int io, input int s,
                                   input int r2, input int im, input int sd,
                                   output bit ok, output int w);
        ok = 1'b0;
        w  = 0;
        if (t == 0) begin
            if (ro == 4) begin
                ok = (s < 4);
                w  = (4 << 5) + (s << 3) + r2;
            end else if (ro == 5) begin
                ok = (im < 2);
                w  = (5 << 5) + (s << 2) + (sd << 1) + im;
            end else if (ro == 7) begin
                ok = (im < 32);
                w  = (7 << 5) + im;
            end else begin
                ok = (r2 < 4);
                w  = (ro << 5) + (s << 2) + r2;
            end
        end else if (io < 2) begin
            ok = (im < 8);
            w  = 256 + (io << 6) + (s << 3) + im;
        end else begin
            ok = (s < 2) && (im < 32);
            w  = 256 + (io << 6) + (s << 5) + im;
        end
    endfunction

    // Model state per instance: index 0 is the 32-deep loader, 1 the 4-deep one.
    int depth[2] = '{32, 4};
    int m_cnt[2], m_err[2], m_addr[2], m_wdata[2];
    bit m_we[2], m_ill[2];

    always @(posedge clk) begin
        bit ok;
        int w;
        encode(int'(ritype), int'(rop), int'(iop), int'(rs), int'(rt), int'(imm),
               int'(shift_dir), ok, w);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_cnt[k] = 0; m_err[k] = 0; m_addr[k] = 0; m_wdata[k] = 0;
                m_we[k] = 0; m_ill[k] = 0;
            end else if (clear) begin
                m_cnt[k] = 0; m_err[k] = 0; m_we[k] = 0; m_ill[k] = 0;
            end else begin
                m_we[k]  = 0;
                m_ill[k] = 0;
                if (in_valid && m_cnt[k] < depth[k]) begin
                    if (ok) begin
                        m_we[k] = 1; m_addr[k] = m_cnt[k]; m_wdata[k] = w;
                        m_cnt[k] = m_cnt[k] + 1;
                    end else begin
                        m_ill[k] = 1;
                        if (m_err[k] < 255) m_err[k] = m_err[k] + 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both loaders against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdy5",  32'(rdy5),  32'((m_cnt[0] < 32) && !clear));
            chk("we5",   32'(we5),   32'(m_we[0]));
            chk("addr5", 32'(addr5), 32'(m_addr[0]));
            chk("wd5",   32'(wd5),   32'(m_wdata[0]));
            chk("cnt5",  32'(cnt5),  32'(m_cnt[0]));
            chk("full5", 32'(full5), 32'(m_cnt[0] == 32));
            chk("ill5",  32'(ill5),  32'(m_ill[0]));
            chk("err5",  32'(err5),  32'(m_err[0]));
            chk("rdy2",  32'(rdy2),  32'((m_cnt[1] < 4) && !clear));
            chk("we2",   32'(we2),   32'(m_we[1]));
            chk("addr2", 32'(addr2), 32'(m_addr[1]));
            chk("wd2",   32'(wd2),   32'(m_wdata[1]));
            chk("cnt2",  32'(cnt2),  32'(m_cnt[1]));
            chk("full2", 32'(full2), 32'(m_cnt[1] == 4));
            chk("ill2",  32'(ill2),  32'(m_ill[1]));
            chk("err2",  32'(err2),  32'(m_err[1]));
        end
    end

    // Advance one cycle; inputs change 1 time unit after the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_b(input int t, input int ro, input int io, input int s,
                         input int r2, input int im, input int sd);
        ritype    = 1'(t);
        rop       = 3'(ro);
        iop       = 2'(io);
        rs        = 3'(s);
        rt        = 3'(r2);
        imm       = 8'(im);
        shift_dir = 1'(sd);
        in_valid  = 1'b1;
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        set_b(0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_cnt5", 32'(cnt5), 32'd0);
        chk("rst_we5",  32'(we5),  32'd0);
        reset = 1'b0;
        #1;
        chk("rst_rdy5", 32'(rdy5), 32'd1);

        // ADD rs=5 rt=2
        set_b(0, 0, 0, 5, 2, 0, 0);
        step();
        in_valid = 1'b0;
        chk("t1_we",   32'(we5),   32'd1);
        chk("t1_addr", 32'(addr5), 32'd0);
        chk("t1_wd",   32'(wd5),   32'h016);
        chk("t1_cnt",  32'(cnt5),  32'd1);
        step();
        chk("t1_we_drop", 32'(we5), 32'd0);
        chk("t1_hold",    32'(wd5), 32'h016);

        // MOV, LD, BEQZ back to back from a cleared loader
        do_clear();
        set_b(0, 4, 0, 3, 7, 0, 0);
        step();
        chk("t2_mov", 32'(wd5), 32'h09F);
        chk("t2_a0",  32'(addr5), 32'd0);
        set_b(1, 0, 2, 1, 0, 31, 0);
        step();
        chk("t2_ld", 32'(wd5), 32'h1BF);
        chk("t2_a1", 32'(addr5), 32'd1);
        set_b(1, 0, 0, 4, 0, 3, 0);
        step();
        in_valid = 1'b0;
        chk("t2_beqz", 32'(wd5), 32'h123);
        chk("t2_a2",   32'(addr5), 32'd2);

        // Illegal bundles, then a legal one lands at address 0
        do_clear();
        set_b(0, 0, 0, 0, 4, 0, 0);
        step();
        chk("t3_ill1", 32'(ill5), 32'd1);
        chk("t3_we1",  32'(we5),  32'd0);
        set_b(1, 0, 2, 2, 0, 0, 0);
        step();
        chk("t3_ill2", 32'(ill5), 32'd1);
        set_b(0, 5, 0, 0, 0, 2, 0);
        step();
        in_valid = 1'b0;
        chk("t3_ill3", 32'(ill5), 32'd1);
        chk("t3_err",  32'(err5), 32'd3);
        chk("t3_cnt",  32'(cnt5), 32'd0);
        set_b(0, 1, 0, 1, 3, 0, 0);
        step();
        in_valid = 1'b0;
        chk("t3_addr", 32'(addr5), 32'd0);
        chk("t3_wd",   32'(wd5),   32'h027);

        // Remaining formats, legal and out of range
        set_b(0, 5, 0, 2, 0, 1, 1);  step(); chk("shift", 32'(wd5), 32'h0AB);
        set_b(0, 7, 0, 0, 0, 21, 0); step(); chk("jmp",   32'(wd5), 32'h0F5);
        set_b(1, 0, 1, 7, 0, 5, 0);  step(); chk("li",    32'(wd5), 32'h17D);
        set_b(1, 0, 3, 0, 0, 9, 0);  step(); chk("str",   32'(wd5), 32'h1C9);
        set_b(0, 6, 0, 6, 1, 0, 0);  step(); chk("r110",  32'(wd5), 32'h0D9);
        set_b(0, 7, 0, 0, 0, 32, 0); step(); chk("jmp_ill", 32'(ill5), 32'd1);
        set_b(1, 0, 1, 0, 0, 8, 0);  step(); chk("li_ill",  32'(ill5), 32'd1);
        set_b(1, 0, 3, 1, 0, 32, 0); step(); chk("str_ill", 32'(ill5), 32'd1);
        set_b(0, 4, 0, 4, 0, 0, 0);  step(); chk("mov_ill", 32'(ill5), 32'd1);
        in_valid = 1'b0;

        // Error counter saturates at 255
        do_clear();
        set_b(0, 0, 0, 0, 4, 0, 0);
        for (int i = 0; i < 258; i++) step();
        in_valid = 1'b0;
        chk("err_sat", 32'(err5), 32'd255);

        // Fill the 4-deep loader, then hold a fifth bundle
        do_clear();
        for (int i = 0; i < 4; i++) begin
            set_b(0, 0, 0, i, 1, 0, 0);
            step();
            chk("t4_addr", 32'(addr2), 32'(i));
            chk("t4_we",   32'(we2),   32'd1);
        end
        chk("t4_full", 32'(full2), 32'd1);
        chk("t4_rdy",  32'(rdy2),  32'd0);
        set_b(1, 0, 1, 2, 0, 6, 0);
        step();
        chk("t4_nowe", 32'(we2),  32'd0);
        chk("t4_cnt",  32'(cnt2), 32'd4);

        // Clear while full with the fifth bundle still offered
        clear = 1'b1;
        #1;
        chk("t5_rdy_clr", 32'(rdy2), 32'd0);
        step();
        clear = 1'b0;
        chk("t5_cnt0",  32'(cnt2),  32'd0);
        chk("t5_full0", 32'(full2), 32'd0);
        chk("t5_we0",   32'(we2),   32'd0);
        step();
        in_valid = 1'b0;
        chk("t5_we",   32'(we2),   32'd1);
        chk("t5_addr", 32'(addr2), 32'd0);
        chk("t5_wd",   32'(wd2),   32'h156);

        // Reset on a handshake edge drops the transfer
        set_b(0, 0, 0, 5, 2, 0, 0);
        reset = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t6_we",  32'(we5),  32'd0);
        chk("t6_wd",  32'(wd5),  32'd0);
        chk("t6_cnt", 32'(cnt2), 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_rdy", 32'(rdy2), 32'd1);
        step();
        chk("t6_we_after", 32'(we5), 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
